// File: rtl/iz_pkg.sv
// Shared constants for the Izhikevich neuron chain: core, spike monitor and readout.
// Holds the monitor parameter defaults and the 8-bit sign/magnitude V_out format.
package iz_pkg;

    localparam int IZ_WIN_CYCLES = 1024;
    localparam int IZ_ISI_W      = 16;
    localparam int IZ_CNT_W      = 8;
    localparam int IZ_BURST_ISI  = 32;

    // V_out is {sign, 7 magnitude bits}
    localparam int IZ_V_W        = 8;
    localparam int IZ_V_SIGN_BIT = IZ_V_W - 1;

    typedef logic [IZ_V_W-1:0] iz_vout_t;

endpackage

// File: rtl/iz_spike_monitor_if.sv
// Summary-record channel from the spike monitor to readout/host logic.
// The record fields are qualified by out_valid and accepted with out_ready.
interface iz_spike_monitor_if #(
    parameter int ISI_W = 16,
    parameter int CNT_W = 8
);
    import iz_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic [CNT_W-1:0] out_bursts;
    logic [ISI_W-1:0] out_min_isi;
    logic [ISI_W-1:0] out_last_isi;
    iz_vout_t         out_last_v;

    modport master (
        output out_valid, out_count, out_bursts, out_min_isi, out_last_isi, out_last_v,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_count, out_bursts, out_min_isi, out_last_isi, out_last_v,
        output out_ready
    );

endinterface

// File: rtl/iz_isi_tracker.sv
// Spike rising-edge detector and inter-spike-interval counter.
// last_isi persists across windows; clear restarts ISI tracking but keeps the edge history.
module iz_isi_tracker #(
    parameter int ISI_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             spike_i,
    output logic             evt_o,
    output logic             spike_evt_o,
    output logic             isi_valid_o,
    output logic [ISI_W-1:0] isi_o,
    output logic [ISI_W-1:0] last_isi_next_o
);

    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic             spike_q;
    logic             spike_evt_q;
    logic             have_prev_q;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [ISI_W-1:0] last_isi_q, last_isi_d;

    // clear swallows a coincident edge; spike_q keeps tracking so a held level stays silent
    assign evt_o       = spike_i & ~spike_q & ~clear_i;
    assign isi_valid_o = evt_o & have_prev_q;
    assign isi_o       = isi_cnt_q;

    always_comb begin
        isi_cnt_d = isi_cnt_q;
        if (clear_i) begin
            isi_cnt_d = '0;
        end else if (evt_o) begin
            isi_cnt_d = ISI_W'(1);
        end else if (isi_cnt_q != ISI_MAX) begin
            isi_cnt_d = isi_cnt_q + 1'b1;
        end
        last_isi_d = isi_valid_o ? isi_cnt_q : last_isi_q;
    end

    assign last_isi_next_o = last_isi_d;
    assign spike_evt_o     = spike_evt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_q     <= 1'b0;
            spike_evt_q <= 1'b0;
            have_prev_q <= 1'b0;
            isi_cnt_q   <= '0;
            last_isi_q  <= '0;
        end else begin
            spike_q     <= spike_i;
            spike_evt_q <= evt_o;
            have_prev_q <= clear_i ? 1'b0 : (have_prev_q | evt_o);
            isi_cnt_q   <= isi_cnt_d;
            last_isi_q  <= last_isi_d;
        end
    end

endmodule

// File: rtl/iz_spike_monitor.sv
// Windowed spike statistics for the Izhikevich core: counts, bursts, ISI and V at last spike.
// One summary record per window; a close while the previous record is unaccepted sets overrun.
module iz_spike_monitor
    import iz_pkg::*;
#(
    parameter int WIN_CYCLES = IZ_WIN_CYCLES,
    parameter int ISI_W      = IZ_ISI_W,
    parameter int CNT_W      = IZ_CNT_W,
    parameter int BURST_ISI  = IZ_BURST_ISI
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                spike,
    input  iz_vout_t            v_in,
    input  logic                clear,
    output logic                spike_evt,
    output logic                overrun,
    iz_spike_monitor_if.master  out_if
);

    localparam int               WIN_W     = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [ISI_W-1:0] ISI_MAX   = '1;
    localparam logic [31:0]      BURST_LIM = BURST_ISI;

    logic             evt, isi_valid;
    logic [ISI_W-1:0] isi, last_isi_next;

    iz_isi_tracker #(.ISI_W(ISI_W)) u_isi (
        .clk             (clk),
        .rst             (rst),
        .clear_i         (clear),
        .spike_i         (spike),
        .evt_o           (evt),
        .spike_evt_o     (spike_evt),
        .isi_valid_o     (isi_valid),
        .isi_o           (isi),
        .last_isi_next_o (last_isi_next)
    );

    logic [WIN_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] spike_cnt_q, spike_cnt_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [ISI_W-1:0] min_q, min_d;
    iz_vout_t         last_v_q, last_v_d;

    logic             out_valid_q, overrun_q;
    logic [CNT_W-1:0] out_count_q, out_bursts_q;
    logic [ISI_W-1:0] out_min_isi_q, out_last_isi_q;
    iz_vout_t         out_last_v_q;

    logic terminal, is_burst, load_ok;

    assign terminal = (win_cnt_q == WIN_LAST);
    assign is_burst = isi_valid && (32'(isi) <= BURST_LIM);
    assign load_ok  = ~out_valid_q | out_if.out_ready;

    // Accumulator values including this cycle's event, so a terminal-cycle spike is counted
    always_comb begin
        spike_cnt_d = spike_cnt_q;
        burst_cnt_d = burst_cnt_q;
        min_d       = min_q;
        last_v_d    = last_v_q;
        if (evt) begin
            if (spike_cnt_q != CNT_MAX) spike_cnt_d = spike_cnt_q + 1'b1;
            last_v_d = v_in;
        end
        if (is_burst && (burst_cnt_q != CNT_MAX)) burst_cnt_d = burst_cnt_q + 1'b1;
        if (isi_valid && (isi < min_q)) min_d = isi;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_cnt_q      <= '0;
            spike_cnt_q    <= '0;
            burst_cnt_q    <= '0;
            min_q          <= ISI_MAX;
            last_v_q       <= '0;
            out_valid_q    <= 1'b0;
            overrun_q      <= 1'b0;
            out_count_q    <= '0;
            out_bursts_q   <= '0;
            out_min_isi_q  <= ISI_MAX;
            out_last_isi_q <= '0;
            out_last_v_q   <= '0;
        end else if (clear) begin
            win_cnt_q      <= '0;
            spike_cnt_q    <= '0;
            burst_cnt_q    <= '0;
            min_q          <= ISI_MAX;
            last_v_q       <= '0;
            out_valid_q    <= 1'b0;
            overrun_q      <= 1'b0;
            out_count_q    <= '0;
            out_bursts_q   <= '0;
            out_min_isi_q  <= ISI_MAX;
            out_last_isi_q <= '0;
            out_last_v_q   <= '0;
        end else begin
            win_cnt_q <= terminal ? '0 : win_cnt_q + 1'b1;
            if (out_valid_q && out_if.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (terminal) begin
                spike_cnt_q <= '0;
                burst_cnt_q <= '0;
                min_q       <= ISI_MAX;
                last_v_q    <= '0;
                if (load_ok) begin
                    out_valid_q    <= 1'b1;
                    out_count_q    <= spike_cnt_d;
                    out_bursts_q   <= burst_cnt_d;
                    out_min_isi_q  <= min_d;
                    out_last_isi_q <= last_isi_next;
                    out_last_v_q   <= last_v_d;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else begin
                spike_cnt_q <= spike_cnt_d;
                burst_cnt_q <= burst_cnt_d;
                min_q       <= min_d;
                last_v_q    <= last_v_d;
            end
        end
    end

    assign overrun             = overrun_q;
    assign out_if.out_valid    = out_valid_q;
    assign out_if.out_count    = out_count_q;
    assign out_if.out_bursts   = out_bursts_q;
    assign out_if.out_min_isi  = out_min_isi_q;
    assign out_if.out_last_isi = out_last_isi_q;
    assign out_if.out_last_v   = out_last_v_q;

endmodule

// File: tb/tb_iz_spike_monitor.sv
// Bench for iz_spike_monitor: two instances (64- and 1024-cycle windows) share one stimulus stream.
// An abstract per-instance model (absolute rise times) queues expected records; a monitor pops them.
module tb_iz_spike_monitor;

    typedef struct {
        int count;
        int bursts;
        int min_isi;
        int last_isi;
        int last_v;
    } rec_t;

    localparam int BURST  = 8;
    localparam int SAT_C  = 255;
    localparam int SAT_I  = 65535;

    logic       clk = 1'b0;
    logic       rst;
    logic       spike;
    logic [7:0] v_in;
    logic       clear;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int WIN = (gi == 0) ? 64 : 1024;

        iz_spike_monitor_if #(.ISI_W(16), .CNT_W(8)) dif ();
        logic evt_o, ovr_o;
        assign dif.out_ready = out_ready;

        iz_spike_monitor #(
            .WIN_CYCLES (WIN),
            .ISI_W      (16),
            .CNT_W      (8),
            .BURST_ISI  (BURST)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .spike     (spike),
            .v_in      (v_in),
            .clear     (clear),
            .spike_evt (evt_o),
            .overrun   (ovr_o),
            .out_if    (dif.master)
        );

        rec_t   exp_q[$];
        longint t, win_start, last_rise;
        bit     prev_sp, have_rise, m_valid, m_ovr, m_evt;
        int     w_cnt, w_burst, w_min, w_lastv, last_isi;

        // Reference model: statistics from absolute rise times and window boundaries
        initial forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                t = 0; win_start = 0; last_rise = 0;
                prev_sp = 0; have_rise = 0; m_valid = 0; m_ovr = 0; m_evt = 0;
                w_cnt = 0; w_burst = 0; w_min = SAT_I; w_lastv = 0; last_isi = 0;
                exp_q.delete();
            end else begin
                bit rise, load_ok, close;
                int isi;
                rise    = spike && !prev_sp;
                prev_sp = spike;
                if (clear) begin
                    m_valid = 0; m_ovr = 0; m_evt = 0; have_rise = 0;
                    w_cnt = 0; w_burst = 0; w_min = SAT_I; w_lastv = 0;
                    win_start = t + 1;
                    exp_q.delete();
                end else begin
                    m_evt = rise;
                    if (rise) begin
                        w_cnt++;
                        w_lastv = v_in;
                        if (have_rise) begin
                            isi = (t - last_rise > SAT_I) ? SAT_I : int'(t - last_rise);
                            last_isi = isi;
                            if (isi < w_min) w_min = isi;
                            if (isi <= BURST) w_burst++;
                        end
                        have_rise = 1;
                        last_rise = t;
                    end
                    close   = ((t - win_start) % WIN) == WIN - 1;
                    load_ok = !m_valid || out_ready;
                    if (m_valid && out_ready) m_valid = 0;
                    if (close) begin
                        if (load_ok) begin
                            rec_t r;
                            r.count    = (w_cnt > SAT_C) ? SAT_C : w_cnt;
                            r.bursts   = (w_burst > SAT_C) ? SAT_C : w_burst;
                            r.min_isi  = w_min;
                            r.last_isi = last_isi;
                            r.last_v   = w_lastv;
                            exp_q.push_back(r);
                            m_valid = 1;
                        end else begin
                            m_ovr = 1;
                        end
                        w_cnt = 0; w_burst = 0; w_min = SAT_I; w_lastv = 0;
                    end
                end
                t++;
            end
        end

        // Monitor: mid-cycle, compare status and pop/compare a record on each handshake
        initial forever begin
            @(negedge clk);
            if (rst) begin
                chk($sformatf("i%0d out_valid", gi), int'(dif.out_valid), int'(m_valid));
                chk($sformatf("i%0d overrun", gi), int'(ovr_o), int'(m_ovr));
                chk($sformatf("i%0d spike_evt", gi), int'(evt_o), int'(m_evt));
                if (dif.out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk($sformatf("i%0d unexpected_record", gi), 1, 0);
                    end else begin
                        rec_t r;
                        r = exp_q.pop_front();
                        chk($sformatf("i%0d out_count", gi), int'(dif.out_count), r.count);
                        chk($sformatf("i%0d out_bursts", gi), int'(dif.out_bursts), r.bursts);
                        chk($sformatf("i%0d out_min_isi", gi), int'(dif.out_min_isi), r.min_isi);
                        chk($sformatf("i%0d out_last_isi", gi), int'(dif.out_last_isi), r.last_isi);
                        chk($sformatf("i%0d out_last_v", gi), int'(dif.out_last_v), r.last_v);
                    end
                end
            end
        end

        // Asynchronous reset must force reset values without waiting for a clock
        initial forever begin
            @(negedge rst);
            #1;
            chk($sformatf("i%0d rst out_valid", gi), int'(dif.out_valid), 0);
            chk($sformatf("i%0d rst overrun", gi), int'(ovr_o), 0);
            chk($sformatf("i%0d rst spike_evt", gi), int'(evt_o), 0);
            chk($sformatf("i%0d rst out_count", gi), int'(dif.out_count), 0);
            chk($sformatf("i%0d rst out_bursts", gi), int'(dif.out_bursts), 0);
            chk($sformatf("i%0d rst out_min_isi", gi), int'(dif.out_min_isi), SAT_I);
            chk($sformatf("i%0d rst out_last_isi", gi), int'(dif.out_last_isi), 0);
            chk($sformatf("i%0d rst out_last_v", gi), int'(dif.out_last_v), 0);
        end
    end

    task automatic tick(input logic s, input logic [7:0] v, input logic rdy, input logic clr);
        spike     = s;
        v_in      = v;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic s;
        rst = 1'b1; spike = 1'b0; v_in = 8'h00; clear = 1'b0; out_ready = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;

        // Pulses rising at 5, 10, 30; last carries V=0x53
        for (int c = 0; c < 64; c++)
            tick((c == 5 || c == 6 || c == 10 || c == 11 || c == 30 || c == 31),
                 (c == 30 || c == 31) ? 8'h53 : 8'h00, 1'b1, 1'b0);
        // A silent window
        for (int c = 0; c < 64; c++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        // Consumer stalled across two closes, then released
        for (int c = 0; c < 128; c++) tick((c == 20 || c == 100), 8'(c), 1'b0, 1'b0);
        for (int c = 0; c < 64; c++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        // Rise on the terminal cycle, then one early in the next window
        for (int c = 0; c < 192; c++)
            tick((c == 63 || c == 64 || c == 74 || c == 75), (c == 63) ? 8'h91 : 8'h22, 1'b1, 1'b0);

        // 300 spikes at ISI 2, then idle until the long window closes
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        for (int c = 0; c < 600; c++) tick((c % 2) == 0, 8'($urandom), 1'b1, 1'b0);
        for (int c = 0; c < 1100; c++) tick(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with stalls and occasional clears
        s = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(2, 0) == 0) s = ~s;
            tick(s, 8'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(499, 0) == 0));
        end

        // Spike rising together with clear and held high: no event
        tick(1'b1, 8'h11, 1'b1, 1'b1);
        for (int c = 0; c < 20; c++) tick(1'b1, 8'h11, 1'b1, 1'b0);
        // Async reset mid-window
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(3, 0) == 0) s = ~s;
            tick(s, 8'($urandom), 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
